// File: rtl/booth_aq_register_if.sv
// rtl/booth_aq_register_if.sv - controller/datapath bundle for the Booth A/Q/Q-1 register
// The controller holds the master side; the register datapath holds the slave side.
interface booth_aq_register_if #(
  parameter int DATA_WIDTH = 16
);
  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic                      load;
  logic                      step;
  logic [1:0]                op;
  logic [DATA_WIDTH-1:0]     mcand_in;
  logic [DATA_WIDTH-1:0]     mplier_in;
  logic [DATA_WIDTH-1:0]     a_out;
  logic [DATA_WIDTH-1:0]     q_out;
  logic                      q_m1;
  logic [1:0]                booth_pair;
  logic [2*DATA_WIDTH-1:0]   product;
  logic [CW-1:0]             count;
  logic                      busy;
  logic                      done;

  modport master (
    output load, step, op, mcand_in, mplier_in,
    input  a_out, q_out, q_m1, booth_pair, product, count, busy, done
  );

  modport slave (
    input  load, step, op, mcand_in, mplier_in,
    output a_out, q_out, q_m1, booth_pair, product, count, busy, done
  );
endinterface

// File: rtl/booth_aq_register.sv
// rtl/booth_aq_register.sv - combined A/Q/Q-1/M register with step counter for a sequential Booth multiplier
// One step adds/subtracts M into A, then arithmetic-shifts {A,Q,Q-1} right by one bit.
module booth_aq_register #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 clear,
  booth_aq_register_if.slave   bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  q_q, q_d;
  logic [W-1:0]  m_q, m_d;
  logic          qm1_q, qm1_d;
  logic [CW-1:0] count_q, count_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // One extra sign bit keeps A-M exact even for M = -2^(W-1).
  logic [W:0]    a_ext;
  logic [W:0]    m_ext;
  logic [W:0]    sum;

  always_comb begin
    a_ext = {a_q[W-1], a_q};
    m_ext = {m_q[W-1], m_q};
    case (bus.op)
      2'b01:   sum = a_ext + m_ext;
      2'b10:   sum = a_ext - m_ext;
      default: sum = a_ext;
    endcase
  end

  always_comb begin
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    qm1_d   = qm1_q;
    count_d = count_q;
    busy_d  = busy_q;
    done_d  = done_q;

    if (bus.load) begin
      m_d     = bus.mcand_in;
      q_d     = bus.mplier_in;
      a_d     = '0;
      qm1_d   = 1'b0;
      count_d = CW'(W);
      busy_d  = 1'b1;
      done_d  = 1'b0;
    end else if (bus.step && busy_q) begin
      a_d     = sum[W:1];
      q_d     = {sum[0], q_q[W-1:1]};
      qm1_d   = q_q[0];
      count_d = count_q - CW'(1);
      if (count_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      qm1_q   <= 1'b0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      qm1_q   <= qm1_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.a_out      = a_q;
  assign bus.q_out      = q_q;
  assign bus.q_m1       = qm1_q;
  assign bus.booth_pair = {q_q[0], qm1_q};
  assign bus.product    = {a_q, q_q};
  assign bus.count      = count_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_booth_aq_register.sv
// tb/tb_booth_aq_register.sv - directed-vector scoreboard bench for booth_aq_register at W=8
// Products are queued at load and checked by a monitor on each rising edge of done.
module tb_booth_aq_register;
  localparam int W = 8;

  logic clk;
  logic clear;
  logic auto_op;
  logic [1:0] manual_op;

  int checks;
  int errors;

  logic [2*W-1:0] sb_q[$];
  logic           done_prev;

  booth_aq_register_if #(.DATA_WIDTH(W)) bus ();

  booth_aq_register #(.DATA_WIDTH(W)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stand-in for the Booth controller: decode booth_pair into op.
  always_comb begin
    if (auto_op) begin
      case (bus.booth_pair)
        2'b01:   bus.op = 2'b01;
        2'b10:   bus.op = 2'b10;
        default: bus.op = 2'b00;
      endcase
    end else begin
      bus.op = manual_op;
    end
  end

  always @(negedge clk) begin
    if (clear) begin
      done_prev <= 1'b0;
    end else begin
      if (bus.done && !done_prev) begin
        checks = checks + 1;
        if (sb_q.size() == 0) begin
          errors = errors + 1;
          $display("FAIL sb_unexpected_done product=%h expected=none", bus.product);
        end else begin
          logic [2*W-1:0] exp_p;
          exp_p = sb_q.pop_front();
          if (bus.product !== exp_p) begin
            errors = errors + 1;
            $display("FAIL sb_product actual=%h expected=%h", bus.product, exp_p);
          end
        end
      end
      done_prev <= bus.done;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a"},       32'(bus.a_out), 0);
    chk({tag, "_q"},       32'(bus.q_out), 0);
    chk({tag, "_qm1"},     32'(bus.q_m1), 0);
    chk({tag, "_pair"},    32'(bus.booth_pair), 0);
    chk({tag, "_product"}, 32'(bus.product), 0);
    chk({tag, "_count"},   32'(bus.count), 0);
    chk({tag, "_busy"},    32'(bus.busy), 0);
    chk({tag, "_done"},    32'(bus.done), 0);
  endtask

  task automatic run_mult(input logic [W-1:0] m, input logic [W-1:0] q,
                          input logic [2*W-1:0] exp_p, input int gap, input string tag);
    logic [W-1:0] a_s;
    logic [W-1:0] q_s;
    @(negedge clk);
    bus.load      = 1'b1;
    bus.step      = 1'b0;
    bus.mcand_in  = m;
    bus.mplier_in = q;
    sb_q.push_back(exp_p);
    @(negedge clk);
    bus.load = 1'b0;
    chk({tag, "_load_busy"},  32'(bus.busy), 1);
    chk({tag, "_load_count"}, 32'(bus.count), W);
    chk({tag, "_load_a"},     32'(bus.a_out), 0);
    chk({tag, "_load_q"},     32'(bus.q_out), 32'(q));
    for (int i = 0; i < W; i++) begin
      if (gap > 0) begin
        bus.step = 1'b0;
        a_s = bus.a_out;
        q_s = bus.q_out;
        repeat (gap) begin
          @(negedge clk);
          chk({tag, "_gap_a"}, 32'(bus.a_out), 32'(a_s));
          chk({tag, "_gap_q"}, 32'(bus.q_out), 32'(q_s));
        end
      end
      if (i < W - 1) chk({tag, "_early_done"}, 32'(bus.done), 0);
      bus.step = 1'b1;
      @(negedge clk);
    end
    bus.step = 1'b0;
    chk({tag, "_done"},    32'(bus.done), 1);
    chk({tag, "_busy"},    32'(bus.busy), 0);
    chk({tag, "_count"},   32'(bus.count), 0);
    chk({tag, "_product"}, 32'(bus.product), 32'(exp_p));
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    auto_op       = 1'b1;
    manual_op     = 2'b00;
    clear         = 1'b1;
    bus.load      = 1'b0;
    bus.step      = 1'b0;
    bus.mcand_in  = '0;
    bus.mplier_in = '0;
    repeat (2) @(negedge clk);
    clear = 1'b0;
    chk_zero("reset");

    run_mult(8'd7,   8'hFD, 16'hFFEB, 0, "m7xm3");

    // Idle steps after done must not disturb anything.
    auto_op   = 1'b0;
    manual_op = 2'b01;
    bus.step  = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("idle_product", 32'(bus.product), 32'h0000FFEB);
      chk("idle_done",    32'(bus.done), 1);
      chk("idle_count",   32'(bus.count), 0);
    end
    bus.step = 1'b0;
    auto_op  = 1'b1;

    run_mult(8'h80, 8'h80, 16'h4000, 0, "min_x_min");
    run_mult(8'h80, 8'h7F, 16'hC080, 0, "min_x_max");
    run_mult(8'd7,  8'hFD, 16'hFFEB, 2, "gapped");

    // Clear mid-operation at count=4.
    @(negedge clk);
    bus.load      = 1'b1;
    bus.mcand_in  = 8'd7;
    bus.mplier_in = 8'hFD;
    @(negedge clk);
    bus.load = 1'b0;
    bus.step = 1'b1;
    repeat (4) @(negedge clk);
    chk("pre_clear_count", 32'(bus.count), 4);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk_zero("clear");
    repeat (5) begin
      @(negedge clk);
      chk("post_clear_busy",  32'(bus.busy), 0);
      chk("post_clear_count", 32'(bus.count), 0);
      chk("post_clear_a",     32'(bus.a_out), 0);
    end

    // load and step together: load wins.
    bus.load      = 1'b1;
    bus.mcand_in  = 8'd7;
    bus.mplier_in = 8'hFD;
    sb_q.push_back(16'hFFEB);
    @(negedge clk);
    bus.load = 1'b0;
    chk("load_step_count", 32'(bus.count), W);
    chk("load_step_a",     32'(bus.a_out), 0);
    chk("load_step_q",     32'(bus.q_out), 32'h000000FD);
    repeat (W) @(negedge clk);
    bus.step = 1'b0;
    chk("load_step_done",    32'(bus.done), 1);
    chk("load_step_product", 32'(bus.product), 32'h0000FFEB);

    // Restart: a second load at count=3 discards the first operation.
    @(negedge clk);
    bus.load      = 1'b1;
    bus.mcand_in  = 8'd3;
    bus.mplier_in = 8'd5;
    @(negedge clk);
    bus.load = 1'b0;
    bus.step = 1'b1;
    repeat (5) @(negedge clk);
    bus.step = 1'b0;
    chk("pre_restart_count", 32'(bus.count), 3);
    run_mult(8'hFB, 8'd6, 16'hFFE2, 0, "restart");

    @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/booth_aq_register.md
# booth_aq_register

Parametrised accumulator/multiplier register for the sequential Booth multiplier datapath. It replaces the plain parallel-load register with a combined A/Q/Q-1 register that also holds the multiplicand M. Each step does an add/subtract of M into A followed by a one-bit arithmetic right shift of {A,Q,Q-1}, and an internal step counter raises `done` after DATA_WIDTH steps. It sits between the Booth controller, which decodes `booth_pair` and drives `op`/`step`, and the product output.

## Interface
- `DATA_WIDTH`, 16, operand width W (≥2); multiplicand and multiplier are W-bit two's complement. Counter width CW = $clog2(W+1) is derived internally.

- `clk`  in  1  single clock; all state updates on rising edge
- `clear`  in  1  synchronous, active-high reset; highest priority
- `load`  in  1  capture operands and start a new multiplication
- `step`  in  1  perform one Booth iteration when busy
- `op`  in  2  iteration operation: 00/11 shift only, 01 A+M then shift, 10 A−M then shift
- `mcand_in`  in  W  multiplicand M, sampled on load
- `mplier_in`  in  W  multiplier, loaded into Q on load
- `a_out`  out  W  accumulator A
- `q_out`  out  W  Q register
- `q_m1`  out  1  Q-1 bit
- `booth_pair`  out  2  {Q[0], q_m1}, for the controller
- `product`  out  2W  {A, Q}, signed product once done
- `count`  out  CW  remaining steps
- `busy`  out  1  multiplication in progress
- `done`  out  1  result valid; level signal

## Operation
- Priority per cycle: clear > load > step > hold.
- clear: A, Q, M, q_m1, count, busy, done ← 0.
- load: M ← mcand_in, Q ← mplier_in, A ← 0, q_m1 ← 0, count ← W, busy ← 1, done ← 0. Load is accepted in any state, so a load while busy restarts the multiplication.
- step with busy=1:
  - Compute S (W+1 bits) = sext(A) + sext(M) for op=01, sext(A) − sext(M) for op=10, sext(A) for 00/11.
  - Then A ← S[W:1], Q ← {S[0], Q[W-1:1]}, q_m1 ← Q[0], count ← count−1.
- Sum width: the W+1-bit sum with S[W] as sign makes every operand pair exact, including M = −2^(W-1) with op=10. The shifted result always fits W bits.
- Completion: a step executed with count=1 also sets busy ← 0 and done ← 1.
- done holds until the next load or clear.
- step with busy=0 is ignored; no state changes.
- step=0 while busy holds all state; gaps between steps are legal.
- `op` is sampled only when a step is taken.
- Outputs are direct register values, with no combinational path from inputs.
- `booth_pair` and `product` are wires from registers.

## Timing
- Reset value of every output is 0, one cycle after clear is sampled high.
- load sampled at edge N: busy=1, count=W, A=0, Q=mplier_in visible after edge N; the first step may be taken at edge N+1.
- `booth_pair` after each edge reflects the new Q/q_m1. The controller decodes it combinationally into `op` for the next edge.
- With step held high, done rises after edge N+W, giving W+1 cycles from load to done; product is valid in the same cycle.
- load and step high together: load wins and the step is discarded.
- clear mid-operation: idle state next cycle; a later step is ignored until load.

## Test plan
- W=8, load M=7, Q=0xFD (−3), step high, op driven from booth_pair (01→add, 10→sub, else shift) → after 8 steps done=1, product=0xFFEB (−21), count=0, busy=0.
- W=8, M=0x80, Q=0x80 (−128×−128), same drive → product=0x4000; M=0x80, Q=0x7F → product=0xC080 (−16256).
- step pulsed every third cycle, same operands as the first scenario → done only after the 8th taken step; A/Q unchanged on idle cycles; product=0xFFEB.
- Step while idle: after done or reset, step=1 with op=01 for 5 cycles → all outputs unchanged, done stays at its prior value.
- clear asserted with count=4 → next cycle all outputs 0. Then load plus step in the same cycle → load wins, count=8 and A=0.
- load asserted with count=3, M=−5, Q=6 → restart; after 8 steps product=0xFFE2 (−30).
